scm_tcdm_port_bridge: RTL
=========================

Name: scm_tcdm_port_bridge

Overview:
- Initiator-side front end for the 3-read/2-write byte-enabled SCM register file.
- Accepts three TCDM-style slave ports and drives the register-file read/write ports:
  - p0: read/write
  - p1: read/write
  - p2: read-only
- Resolves same-address write collisions with round-robin arbitration and generates r_valid/r_rdata for the file's 1-cycle registered read.
- Sits between the cluster interconnect and the register file instance.

Parameters:
- ADDR_WIDTH, 5, word address width; file depth 2**ADDR_WIDTH.
- DATA_WIDTH, 64, data width in bits.
- NUM_BYTE, DATA_WIDTH/8, byte lanes per word.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- p0_req_i  in  1  port 0 request
- p0_gnt_o  out  1  port 0 grant
- p0_wen_i  in  1  1 = read, 0 = write
- p0_add_i  in  ADDR_WIDTH  word address
- p0_wdata_i  in  DATA_WIDTH  write data
- p0_be_i  in  NUM_BYTE  byte enables
- p0_r_valid_o  out  1  response valid
- p0_r_rdata_o  out  DATA_WIDTH  response data
- p1_req_i, p1_gnt_o, p1_wen_i, p1_add_i, p1_wdata_i, p1_be_i, p1_r_valid_o, p1_r_rdata_o: as port 0, for port 1
- p2_req_i  in  1  port 2 read request
- p2_gnt_o  out  1  port 2 grant
- p2_add_i  in  ADDR_WIDTH  address
- p2_r_valid_o  out  1  response valid
- p2_r_rdata_o  out  DATA_WIDTH  response data
- rf_rd_en_a_o, rf_rd_en_b_o, rf_rd_en_c_o  out  1  read enables to file ports A/B/C
- rf_rd_addr_a_o, rf_rd_addr_b_o, rf_rd_addr_c_o  out  ADDR_WIDTH  read addresses
- rf_rd_data_a_i, rf_rd_data_b_i, rf_rd_data_c_i  in  DATA_WIDTH  registered read data from file
- rf_wr_en_a_o, rf_wr_en_b_o  out  1  write enables
- rf_wr_addr_a_o, rf_wr_addr_b_o  out  ADDR_WIDTH  write addresses
- rf_wr_data_a_o, rf_wr_data_b_o  out  DATA_WIDTH  write data
- rf_wr_be_a_o, rf_wr_be_b_o  out  NUM_BYTE  write byte enables

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_n.
- Port mapping:
  - p0 read → file read A; p1 read → read B; p2 → read C.
  - p0 write → file write A; p1 write → write B.
  - Address, data and BE pass straight through to the file.
- Grant is combinational:
  - pX_gnt_o = pX_req_i, except for a lost write collision.
  - All grants and all rf enables are forced 0 while rst_n = 0.
- Collision: p0 and p1 both request a write to the same address in the same cycle (BE ignored).
  - Only one is granted. Round-robin flop rr_q selects the winner: 0 = p0 wins, 1 = p1 wins.
  - rr_q toggles on every cycle a collision is resolved. Reset value of rr_q is 0.
  - The loser sees gnt = 0, must hold its request, and is granted on a later cycle.
- Reads never stall; the three read ports are independent.
- Response timing: pX_r_valid_o = 1 exactly one cycle after each grant, for both reads and writes.
- Response data:
  - Read response: r_rdata = file read data of that port.
  - Write response: r_rdata = 0. A registered was_read flag per port selects between the two.
- Back-to-back grants give back-to-back r_valid; no bubbles. Maximum one outstanding per port.
- Same-cycle read and write to one address (macro off): the read returns the pre-write contents.
- Reset values: all r_valid = 0, was_read = 0, rr_q = 0, all r_rdata = 0.
- Reset asserted mid-operation: pending responses are dropped; no r_valid after reset release for pre-reset grants.

Optional Feature:
- Macro: SCM_BRIDGE_WR_FWD_EN
- With macro defined:
  - Condition: a read granted in the same cycle as a granted write to the same address, on either write port.
  - At most one write can hit a given address per cycle, by the arbitration rule.
  - Per read port, register the write data and BE mask.
  - The response returns file data with BE-selected bytes replaced by the forwarded write bytes, i.e. write-through.
- Without macro: no forwarding registers; the read returns the old contents.

Test Plan:
- Reset then p0 write to addr 3, data 0x1122334455667788, BE 0xFF; next cycle p0 read addr 3 → gnt = 1 both cycles, r_valid on each following cycle, read r_rdata = 0x1122334455667788, write response r_rdata = 0.
- p0 and p1 write addr 7 simultaneously, twice in a row:
  - First collision → p0 granted, p1 gnt = 0.
  - Next collision → p1 granted.
  - rr_q observed as 0 → 1 → 0.
- p0 write addr 5 and p1 write addr 6 in the same cycle → both granted, no stall, both rf write enables high.
- p2 read addr 5 every cycle for 8 cycles → p2_gnt_o constant 1, p2_r_valid_o continuous from cycle 1, data correct.
- Addr 9 holds 0xAAAA...; same cycle p1 writes 0x00FF...00FF with BE 0x0F, and p0 reads addr 9:
  - Macro off → returns 0xAAAAAAAAAAAAAAAA.
  - Macro on → returns 0xAAAAAAAA00FF00FF.
- Assert rst_n low one cycle after a p0 read grant → no p0_r_valid_o after release, rr_q = 0, all outputs 0 during reset.

Source files
------------

// File: rtl/scm_tcdm_port_bridge.sv
// scm_tcdm_port_bridge
//   Initiator-side front end for the 3-read/2-write byte-enabled SCM register
//   file. Three TCDM-style slave ports are mapped onto the file ports:
//     p0 (read/write) -> read A / write A
//     p1 (read/write) -> read B / write B
//     p2 (read only)  -> read C
//   Grants are combinational. A same-address write from p0 and p1 in the same
//   cycle is resolved round-robin (rr_q: 0 = p0 wins, 1 = p1 wins). Responses
//   (r_valid/r_rdata) arrive one cycle after each grant, which matches the
//   file's registered read. Write responses return zero data.
//
//   Optional build macro SCM_BRIDGE_WR_FWD_EN: a read granted together with a
//   granted write to the same address returns the file data with the written
//   bytes (by BE) replaced, i.e. write-through. Without it the read returns
//   the pre-write contents.
//
//   Ports: clk, rst_n (async, active low); p0_*/p1_*/p2_* slave ports;
//   rf_rd_* / rf_wr_* register-file ports.
module scm_tcdm_port_bridge #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // port 0 (read/write)
  input  logic                  p0_req_i,
  output logic                  p0_gnt_o,
  input  logic                  p0_wen_i,
  input  logic [ADDR_WIDTH-1:0] p0_add_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  input  logic [NUM_BYTE-1:0]   p0_be_i,
  output logic                  p0_r_valid_o,
  output logic [DATA_WIDTH-1:0] p0_r_rdata_o,
  // port 1 (read/write)
  input  logic                  p1_req_i,
  output logic                  p1_gnt_o,
  input  logic                  p1_wen_i,
  input  logic [ADDR_WIDTH-1:0] p1_add_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  input  logic [NUM_BYTE-1:0]   p1_be_i,
  output logic                  p1_r_valid_o,
  output logic [DATA_WIDTH-1:0] p1_r_rdata_o,
  // port 2 (read only)
  input  logic                  p2_req_i,
  output logic                  p2_gnt_o,
  input  logic [ADDR_WIDTH-1:0] p2_add_i,
  output logic                  p2_r_valid_o,
  output logic [DATA_WIDTH-1:0] p2_r_rdata_o,
  // register file read ports
  output logic                  rf_rd_en_a_o,
  output logic                  rf_rd_en_b_o,
  output logic                  rf_rd_en_c_o,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr_a_o,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr_b_o,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr_c_o,
  input  logic [DATA_WIDTH-1:0] rf_rd_data_a_i,
  input  logic [DATA_WIDTH-1:0] rf_rd_data_b_i,
  input  logic [DATA_WIDTH-1:0] rf_rd_data_c_i,
  // register file write ports
  output logic                  rf_wr_en_a_o,
  output logic                  rf_wr_en_b_o,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr_a_o,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr_b_o,
  output logic [DATA_WIDTH-1:0] rf_wr_data_a_o,
  output logic [DATA_WIDTH-1:0] rf_wr_data_b_o,
  output logic [NUM_BYTE-1:0]   rf_wr_be_a_o,
  output logic [NUM_BYTE-1:0]   rf_wr_be_b_o
);

  logic       rr_q;
  logic       wr_req_0, wr_req_1, collide;
  logic       gnt_0, gnt_1, gnt_2;
  logic       rd_en_a, rd_en_b, wr_en_a, wr_en_b;
  logic [2:0] r_valid_q, was_read_q;

  // Collision ignores BE: any two writes to the same word contend.
  assign wr_req_0 = p0_req_i & ~p0_wen_i;
  assign wr_req_1 = p1_req_i & ~p1_wen_i;
  assign collide  = wr_req_0 & wr_req_1 & (p0_add_i == p1_add_i);

  // rst_n gates the grants so nothing reaches the file while in reset.
  assign gnt_0 = rst_n & p0_req_i & ~(collide & rr_q);
  assign gnt_1 = rst_n & p1_req_i & ~(collide & ~rr_q);
  assign gnt_2 = rst_n & p2_req_i;

  assign p0_gnt_o = gnt_0;
  assign p1_gnt_o = gnt_1;
  assign p2_gnt_o = gnt_2;

  assign rd_en_a = gnt_0 & p0_wen_i;
  assign rd_en_b = gnt_1 & p1_wen_i;
  assign wr_en_a = gnt_0 & ~p0_wen_i;
  assign wr_en_b = gnt_1 & ~p1_wen_i;

  assign rf_rd_en_a_o   = rd_en_a;
  assign rf_rd_en_b_o   = rd_en_b;
  assign rf_rd_en_c_o   = gnt_2;
  assign rf_rd_addr_a_o = p0_add_i;
  assign rf_rd_addr_b_o = p1_add_i;
  assign rf_rd_addr_c_o = p2_add_i;

  assign rf_wr_en_a_o   = wr_en_a;
  assign rf_wr_en_b_o   = wr_en_b;
  assign rf_wr_addr_a_o = p0_add_i;
  assign rf_wr_addr_b_o = p1_add_i;
  assign rf_wr_data_a_o = p0_wdata_i;
  assign rf_wr_data_b_o = p1_wdata_i;
  assign rf_wr_be_a_o   = p0_be_i;
  assign rf_wr_be_b_o   = p1_be_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= 1'b0;
      r_valid_q  <= '0;
      was_read_q <= '0;
    end else begin
      if (collide) rr_q <= ~rr_q;
      r_valid_q  <= {gnt_2, gnt_1, gnt_0};
      was_read_q <= {gnt_2, rd_en_b, rd_en_a};
    end
  end

  assign p0_r_valid_o = r_valid_q[0];
  assign p1_r_valid_o = r_valid_q[1];
  assign p2_r_valid_o = r_valid_q[2];

  logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b, rd_data_c;

`ifdef SCM_BRIDGE_WR_FWD_EN
  // Per read port: capture the same-cycle write to the same address. A zero
  // BE mask means "no hit", so no separate hit flag is needed.
  logic [2:0]                 fwd_rd_en;
  logic [2:0][ADDR_WIDTH-1:0] fwd_rd_addr;
  logic [2:0][DATA_WIDTH-1:0] fwd_data_d, fwd_data_q;
  logic [2:0][NUM_BYTE-1:0]   fwd_be_d, fwd_be_q;

  assign fwd_rd_en   = {gnt_2, rd_en_b, rd_en_a};
  assign fwd_rd_addr = {p2_add_i, p1_add_i, p0_add_i};

  always_comb begin
    fwd_data_d = '0;
    fwd_be_d   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (fwd_rd_en[i] && wr_en_a && (p0_add_i == fwd_rd_addr[i])) begin
        fwd_data_d[i] = p0_wdata_i;
        fwd_be_d[i]   = p0_be_i;
      end else if (fwd_rd_en[i] && wr_en_b && (p1_add_i == fwd_rd_addr[i])) begin
        fwd_data_d[i] = p1_wdata_i;
        fwd_be_d[i]   = p1_be_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_data_q <= '0;
      fwd_be_q   <= '0;
    end else begin
      fwd_data_q <= fwd_data_d;
      fwd_be_q   <= fwd_be_d;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] fwd_merge(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] fwd,
    input logic [NUM_BYTE-1:0]   be
  );
    logic [DATA_WIDTH-1:0] res;
    res = base;
    for (int unsigned b = 0; b < NUM_BYTE; b++) begin
      if (be[b]) res[b*8 +: 8] = fwd[b*8 +: 8];
    end
    return res;
  endfunction

  assign rd_data_a = fwd_merge(rf_rd_data_a_i, fwd_data_q[0], fwd_be_q[0]);
  assign rd_data_b = fwd_merge(rf_rd_data_b_i, fwd_data_q[1], fwd_be_q[1]);
  assign rd_data_c = fwd_merge(rf_rd_data_c_i, fwd_data_q[2], fwd_be_q[2]);
`else
  assign rd_data_a = rf_rd_data_a_i;
  assign rd_data_b = rf_rd_data_b_i;
  assign rd_data_c = rf_rd_data_c_i;
`endif

  // was_read_q is clear after reset and after write grants, giving zero data.
  assign p0_r_rdata_o = was_read_q[0] ? rd_data_a : '0;
  assign p1_r_rdata_o = was_read_q[1] ? rd_data_b : '0;
  assign p2_r_rdata_o = was_read_q[2] ? rd_data_c : '0;

endmodule
